// File: rtl/program_loader.sv
// program_loader: writer side of the instruction-memory interface.
// Receives a byte stream (CNT_HI, CNT_LO, 4*N data bytes MSB-first, CHK),
// writes each assembled 32-bit instruction at byte address 4*k and holds the
// core in reset until a load with a matching checksum has completed.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-low reset
//   start           load request (honoured in IDLE/DONE/ERR only)
//   byte_in/valid   stream byte and its qualifier
//   byte_ready      loader accepts a byte this cycle
//   mem_we/addr/wdata  one-cycle instruction-memory write
//   core_hold       1 = keep core in reset, PC and IF/ID disabled
//   load_done       verified load complete (level)
//   load_err        load failed (level); err_code 01 = oversize, 10 = checksum
//   words_loaded    words written in the current load
module program_loader #(
  parameter int MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_err,
  output logic [1:0]  err_code,
  output logic [6:0]  words_loaded
);

  typedef enum logic [2:0] {
    IDLE, CNT_HI, CNT_LO, DATA, CHECK, DONE, ERR
  } state_t;

  state_t      state;
  logic [7:0]  cnt_hi;
  logic [6:0]  num_words;
  logic [7:0]  checksum;
  logic [1:0]  byte_idx;
  logic [23:0] shift;

  logic        accept;
  logic [15:0] cnt_full;
  logic [7:0]  sum_next;

  assign accept   = byte_valid && byte_ready;
  assign cnt_full = {cnt_hi, byte_in};
  assign sum_next = checksum + byte_in;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      cnt_hi       <= '0;
      num_words    <= '0;
      checksum     <= '0;
      byte_idx     <= '0;
      shift        <= '0;
      byte_ready   <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      core_hold    <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      err_code     <= 2'b00;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= CNT_HI;
            byte_ready   <= 1'b1;
            core_hold    <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            err_code     <= 2'b00;
            words_loaded <= '0;
            checksum     <= '0;
            byte_idx     <= '0;
            num_words    <= '0;
          end
        end
        CNT_HI: begin
          if (accept) begin
            cnt_hi   <= byte_in;
            checksum <= sum_next;
            state    <= CNT_LO;
          end
        end
        CNT_LO: begin
          if (accept) begin
            checksum  <= sum_next;
            num_words <= cnt_full[6:0];
            if (cnt_full > 16'(MAX_WORDS)) begin
              state      <= ERR;
              byte_ready <= 1'b0;
              load_err   <= 1'b1;
              err_code   <= 2'b01;
            end else if (cnt_full == 16'd0) begin
              state <= CHECK;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            checksum <= sum_next;
            shift    <= {shift[15:0], byte_in};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              // words_loaded doubles as the word index of the word being written
              mem_we       <= 1'b1;
              mem_addr     <= {words_loaded[5:0], 2'b00};
              mem_wdata    <= {shift, byte_in};
              words_loaded <= words_loaded + 7'd1;
              if (words_loaded + 7'd1 == num_words)
                state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (accept) begin
            byte_ready <= 1'b0;
            if (checksum == byte_in) begin
              state     <= DONE;
              load_done <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
              err_code <= 2'b10;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        core_hold;
  logic        load_done;
  logic        load_err;
  logic [1:0]  err_code;
  logic [6:0]  words_loaded;

  int total = 0;
  int bad   = 0;

  logic [7:0]  stm [16];
  logic [7:0]  wr_addr [8];
  logic [31:0] wr_data [8];
  int          wr_n = 0;

  program_loader #(.MAX_WORDS(64)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_hold(core_hold),
    .load_done(load_done), .load_err(load_err), .err_code(err_code),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Record every write strobe cycle
  always @(negedge clk) begin
    if (mem_we && wr_n < 8) begin
      wr_addr[wr_n] = mem_addr;
      wr_data[wr_n] = mem_wdata;
    end
    if (mem_we) wr_n = wr_n + 1;
  end

  task automatic load_good_stream(input logic [7:0] chk);
    stm[0] = 8'h00; stm[1] = 8'h02;
    stm[2] = 8'hE3; stm[3] = 8'hA0; stm[4] = 8'h10; stm[5] = 8'h05;
    stm[6] = 8'hE2; stm[7] = 8'h81; stm[8] = 8'h10; stm[9] = 8'h03;
    stm[10] = chk;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Sends stm[0..n-1]; each byte is held until byte_ready is seen at a
  // negedge, so the following posedge accepts it. Ends at the negedge after
  // the last accept with byte_valid low.
  task automatic send(input int n, input bit throttle, input int start_at);
    for (int i = 0; i < n; i++) begin
      if (throttle) begin
        @(negedge clk);
        byte_valid = 1'b0;
        start = (i == start_at);
      end
      @(negedge clk);
      start = 1'b0;
      byte_valid = 1'b1;
      byte_in = stm[i];
      for (int t = 0; t < 20 && !byte_ready; t++) @(negedge clk);
      if (!byte_ready) begin
        total++; bad++;
        $display("FAIL send_timeout byte=%0d byte_ready=%b required=1", i, byte_ready);
      end
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic check_two_writes(input string tag);
    total++;
    if (wr_n !== 2) begin bad++; $display("FAIL %s_wr_count got=%0d exp=2", tag, wr_n); end
    total++;
    if (wr_addr[0] !== 8'h00 || wr_data[0] !== 32'hE3A01005) begin
      bad++; $display("FAIL %s_wr0 got=%h:%h exp=00:e3a01005", tag, wr_addr[0], wr_data[0]);
    end
    total++;
    if (wr_addr[1] !== 8'h04 || wr_data[1] !== 32'hE2811003) begin
      bad++; $display("FAIL %s_wr1 got=%h:%h exp=04:e2811003", tag, wr_addr[1], wr_data[1]);
    end
  endtask

  task automatic check_reset_values(input string tag);
    total++;
    if ({byte_ready, mem_we, mem_addr, mem_wdata, core_hold, load_done, load_err,
         err_code, words_loaded} !== {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 2'b00, 7'd0}) begin
      bad++;
      $display("FAIL %s got rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b code=%b wl=%0d exp 0 0 00 0 1 0 0 00 0",
               tag, byte_ready, mem_we, mem_addr, mem_wdata, core_hold, load_done, load_err,
               err_code, words_loaded);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (byte_ready !== 1'b0 || core_hold !== 1'b1) begin
      bad++; $display("FAIL idle_after_reset rdy=%b hold=%b exp 0 1", byte_ready, core_hold);
    end
  endtask

  task automatic test_two_words();
    load_good_stream(8'h10);
    wr_n = 0;
    pulse_start();
    send(11, 1'b0, -1);
    check_two_writes("two_words");
    total++;
    if (load_done !== 1'b1 || core_hold !== 1'b0 || load_err !== 1'b0 || words_loaded !== 7'd2) begin
      bad++; $display("FAIL two_words_done done=%b hold=%b err=%b wl=%0d exp 1 0 0 2",
                      load_done, core_hold, load_err, words_loaded);
    end
    total++;
    if (byte_ready !== 1'b0 || mem_wdata !== 32'hE2811003) begin
      bad++; $display("FAIL two_words_hold rdy=%b wdata=%h exp 0 e2811003", byte_ready, mem_wdata);
    end
  endtask

  task automatic test_empty();
    stm[0] = 8'h00; stm[1] = 8'h00; stm[2] = 8'h00;
    wr_n = 0;
    pulse_start();
    total++;
    if (load_done !== 1'b0 || words_loaded !== 7'd0 || core_hold !== 1'b1) begin
      bad++; $display("FAIL restart_clear done=%b wl=%0d hold=%b exp 0 0 1", load_done, words_loaded, core_hold);
    end
    send(3, 1'b0, -1);
    total++;
    if (wr_n !== 0 || load_done !== 1'b1 || words_loaded !== 7'd0 || core_hold !== 1'b0) begin
      bad++; $display("FAIL empty writes=%0d done=%b wl=%0d hold=%b exp 0 1 0 0",
                      wr_n, load_done, words_loaded, core_hold);
    end
  endtask

  task automatic test_oversize();
    stm[0] = 8'h00; stm[1] = 8'h41;
    wr_n = 0;
    pulse_start();
    send(2, 1'b0, -1);
    total++;
    if (load_err !== 1'b1 || err_code !== 2'b01 || core_hold !== 1'b1 || load_done !== 1'b0) begin
      bad++; $display("FAIL oversize err=%b code=%b hold=%b done=%b exp 1 01 1 0",
                      load_err, err_code, core_hold, load_done);
    end
    repeat (3) @(negedge clk);
    total++;
    if (wr_n !== 0 || byte_ready !== 1'b0) begin
      bad++; $display("FAIL oversize_quiet writes=%0d rdy=%b exp 0 0", wr_n, byte_ready);
    end
  endtask

  task automatic test_bad_checksum();
    load_good_stream(8'h11);
    wr_n = 0;
    pulse_start();
    total++;
    if (load_err !== 1'b0 || err_code !== 2'b00) begin
      bad++; $display("FAIL err_restart_clear err=%b code=%b exp 0 00", load_err, err_code);
    end
    send(11, 1'b0, -1);
    check_two_writes("bad_chk");
    total++;
    if (load_err !== 1'b1 || err_code !== 2'b10 || core_hold !== 1'b1 || load_done !== 1'b0) begin
      bad++; $display("FAIL bad_chk err=%b code=%b hold=%b done=%b exp 1 10 1 0",
                      load_err, err_code, core_hold, load_done);
    end
  endtask

  task automatic test_throttled();
    load_good_stream(8'h10);
    wr_n = 0;
    pulse_start();
    send(11, 1'b1, 5);
    check_two_writes("throttled");
    total++;
    if (load_done !== 1'b1 || core_hold !== 1'b0 || words_loaded !== 7'd2 || load_err !== 1'b0) begin
      bad++; $display("FAIL throttled_done done=%b hold=%b wl=%0d err=%b exp 1 0 2 0",
                      load_done, core_hold, words_loaded, load_err);
    end
  endtask

  task automatic test_reset_mid_load();
    load_good_stream(8'h10);
    pulse_start();
    send(6, 1'b0, -1);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset_mid");
    reset = 1'b1;
    wr_n = 0;
    pulse_start();
    send(11, 1'b0, -1);
    check_two_writes("reload");
    total++;
    if (load_done !== 1'b1 || core_hold !== 1'b0 || words_loaded !== 7'd2) begin
      bad++; $display("FAIL reload_done done=%b hold=%b wl=%0d exp 1 0 2",
                      load_done, core_hold, words_loaded);
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_empty();
    test_oversize();
    test_bad_checksum();
    test_throttled();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/program_loader.md
# program_loader

Program loader for the pipelined ARM core: the writer side of the instruction-memory interface the fetch stage reads. It accepts a byte stream (word count, instruction words MSB-first, checksum) and writes each assembled 32-bit instruction into the instruction ROM at byte addresses 0, 4, 8, and so on. It holds the core in reset with PC and IF/ID disabled while loading, and releases it only after a verified load.

## Interface
- MAX_WORDS, 64: instruction memory capacity in words (256 bytes, addressed by pc[7:0]).
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low.
- start  in  1  load request, sampled in IDLE/DONE/ERR.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in valid.
- byte_ready  out  1  loader accepts byte this cycle.
- mem_we  out  1  one-cycle instruction-memory write strobe.
- mem_addr  out  8  byte address of the word being written.
- mem_wdata  out  32  instruction word.
- core_hold  out  1  1 = hold core: reset the core, enable_pc=0, enable_ifid=0.
- load_done  out  1  level, verified load complete.
- load_err  out  1  level, load failed.
- err_code  out  2  01 = count > MAX_WORDS, 10 = checksum mismatch, 00 = none.
- words_loaded  out  7  words written in the current load.

## Operation
- Accept: byte_valid && byte_ready at the rising edge. Bytes are never dropped or duplicated.
- Stream format: CNT_HI, CNT_LO (16-bit word count N), then 4N data bytes (MSB first), then CHK.
- CHK = 8-bit mod-256 sum of CNT_HI, CNT_LO and all data bytes.
- States:
  - IDLE: byte_ready=0; start → CNT_HI.
  - CNT_HI: byte_ready=1; accept → CNT_LO.
  - CNT_LO: byte_ready=1; on accept:
    - N > MAX_WORDS → ERR, err_code=01.
    - N == 0 → CHECK.
    - else → DATA.
  - DATA: byte_ready=1; 2-bit byte index and word counter.
    - After the 4th byte of word k, write word k.
    - After word N-1 → CHECK.
  - CHECK: byte_ready=1; on accept:
    - match → DONE.
    - mismatch → ERR, err_code=10.
  - DONE: load_done=1, core_hold=0; start → CNT_HI.
  - ERR: load_err=1, core_hold=1; start → CNT_HI.
- Restart from DONE or ERR clears load_done, load_err, err_code, words_loaded, checksum and counters.
- start is ignored in CNT_HI, CNT_LO, DATA and CHECK.
- core_hold = 1 in every state except DONE.
- Running checksum is 8 bits and wraps.
- Word counter is 7 bits; mem_addr = {word_index[5:0], 2'b00}.

## Timing
- Reset values: state IDLE, byte_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, core_hold 1, load_done 0, load_err 0, err_code 00, words_loaded 0.
- Registered write: mem_we=1 in the cycle after the 4th byte of a word is accepted, for exactly one cycle.
  - mem_addr and mem_wdata are valid with mem_we.
  - words_loaded increments in that same cycle.
  - mem_wdata holds its value between writes.
- byte_ready stays 1 through write cycles. Zero stall: one byte per cycle is sustainable.
- Gaps in byte_valid are tolerated; state holds.
- Latency from CHK accept to load_done/load_err is 1 cycle. core_hold falls together with load_done.
- If the last word's write and the CHK accept fall in the same cycle, both occur. The write is never suppressed.
- Count error is flagged 1 cycle after CNT_LO accept, with no memory writes.
- Reset mid-load: all outputs return to reset values at that edge and any partial word is discarded. Memory words already written remain in memory.

## Test plan
- Load of 2 words, stream 00 02 E3 A0 10 05 E2 81 10 03 10:
  - mem_we at addr 0x00 with E3A01005.
  - mem_we at addr 0x04 with E2811003.
  - load_done=1, core_hold=0 one cycle after CHK; words_loaded=2.
- Empty load, stream 00 00 00: no mem_we, load_done=1, words_loaded=0.
- Oversize count, stream 00 41: load_err=1, err_code=01 one cycle after CNT_LO, no mem_we, core_hold=1.
- Bad checksum: 2-word stream above with CHK=11 → both writes occur, then load_err=1, err_code=10, core_hold=1.
- Throttled source: the 2-word stream with byte_valid toggling every other cycle gives the same writes and result. start pulsed mid-load is ignored.
- Reset mid-load: reset low after the 6th byte → all outputs at reset values next edge. The full stream is then sent again after start, and the load completes normally with load_done=1.
